// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART core.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  // Tick at which the middle of a bit is reached, counted from its leading edge.
  localparam int MID_TICK   = OVERSAMPLE / 2;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Oversampling tick divisor: truncated, never below 1.
  function automatic int calc_div(input int freq_hz, input int baud);
    int d;
    d = freq_hz / (OVERSAMPLE * baud);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider producing a one-cycle oversampling tick every DIV clocks.
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count 0..DIV-1 and wrap; the wrap cycle is the tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/uart_core.sv
// 8N1 UART transceiver, 16x oversampling, independent full-duplex RX and TX.
//
// Host handshake: tx_wr and rx_ack are single-cycle strobes sampled on the
// rising clock edge. tx_wr is honoured only while tx_busy = 0 and is otherwise
// dropped. rx_avail stays high until an rx_ack; a byte completing in the same
// cycle as rx_ack wins, leaving rx_avail = 1 with the new byte.
//
// dbg_state = {rx_state, tx_state} for observing both FSMs.
module uart_core
  import uart_pkg::*;
#(
  parameter int freq_hz = 100000000,
  parameter int baud    = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy,
  output logic [3:0] dbg_state
);

  localparam int DIV = calc_div(freq_hz, baud);
  localparam logic [3:0] CNT_MID  = 4'(MID_TICK - 1);
  localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic tick;

  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // ---------------- receive ----------------
  logic                 rx_meta, rx_sync;
  rx_state_t            rx_state, rx_state_n;
  logic [3:0]           rx_cnt, rx_cnt_n;
  logic [2:0]           rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_good, rx_bad;

  // Two-flop synchronizer; resets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
    end
  end

  // RX next state: confirm start at mid-bit, then sample every 16 ticks.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_good    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_cnt == CNT_MID) begin
            rx_cnt_n   = '0;
            rx_bit_n   = '0;
            rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_n = rx_cnt + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_cnt_n = rx_cnt + 4'd1;
          if (rx_cnt == CNT_LAST) begin
            rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
            rx_bit_n   = rx_bit + 3'd1;
            if (rx_bit == BIT_LAST) rx_state_n = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          rx_cnt_n = rx_cnt + 4'd1;
          if (rx_cnt == CNT_LAST) begin
            rx_state_n = RX_IDLE;
            rx_good    = rx_sync;
            rx_bad     = !rx_sync;
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // Host-side flags: completion beats ack; framing errors are sticky until ack.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_data  <= '0;
      rx_avail <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      if (rx_good) begin
        rx_data  <= rx_shift;
        rx_avail <= 1'b1;
      end else if (rx_ack) begin
        rx_avail <= 1'b0;
      end
      if (rx_bad) begin
        rx_error <= 1'b1;
      end else if (rx_ack) begin
        rx_error <= 1'b0;
      end
    end
  end

  // ---------------- transmit ----------------
  tx_state_t            tx_state, tx_state_n;
  logic [3:0]           tx_cnt, tx_cnt_n;
  logic [2:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 txd_n;

  // TX next state; the line value is derived from the next state so it is registered.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    case (tx_state)
      TX_IDLE: begin
        if (tx_wr) begin
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_shift_n = tx_data;
        end
      end
      TX_START: begin
        if (tick) begin
          tx_cnt_n = tx_cnt + 4'd1;
          if (tx_cnt == CNT_LAST) begin
            tx_state_n = TX_DATA;
            tx_bit_n   = '0;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          tx_cnt_n = tx_cnt + 4'd1;
          if (tx_cnt == CNT_LAST) begin
            tx_shift_n = {1'b0, tx_shift[DATA_BITS-1:1]};
            tx_bit_n   = tx_bit + 3'd1;
            if (tx_bit == BIT_LAST) tx_state_n = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          tx_cnt_n = tx_cnt + 4'd1;
          if (tx_cnt == CNT_LAST) tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    case (tx_state_n)
      TX_START: txd_n = 1'b0;
      TX_DATA:  txd_n = tx_shift_n[0];
      default:  txd_n = 1'b1;
    endcase
  end

  // TX state register and glitch-free line driver.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      uart_txd <= txd_n;
    end
  end

  assign tx_busy   = (tx_state != TX_IDLE);
  assign dbg_state = {rx_state, tx_state};

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core at DIV = 5 (80 clocks per bit).
module tb_uart_core;

  localparam int FREQ     = 100000000;
  localparam int BAUD     = 1152000;
  localparam int DIV      = 5;
  localparam int BIT_CLKS = 16 * DIV;
  localparam int FRAME    = 10 * BIT_CLKS;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rxd, uart_txd;
  logic [7:0] rx_data;
  logic       rx_avail, rx_error;
  logic       rx_ack = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_wr = 1'b0;
  logic       tx_busy;
  logic [3:0] dbg_state;

  logic loop_en = 1'b0;
  logic rxd_drv = 1'b1;
  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  always #5 clk = ~clk;

  uart_core #(.freq_hz(FREQ), .baud(BAUD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .uart_rxd  (uart_rxd),
    .uart_txd  (uart_txd),
    .rx_data   (rx_data),
    .rx_avail  (rx_avail),
    .rx_error  (rx_error),
    .rx_ack    (rx_ack),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_busy   (tx_busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int         checks = 0;
  int         fails  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_data;
  logic       m_avail, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_data"},  {24'h0, rx_data}, {24'h0, m_data});
    check({tag, "_avail"}, {31'h0, rx_avail}, {31'h0, m_avail});
    check({tag, "_error"}, {31'h0, rx_error}, {31'h0, m_err});
  endtask

  // Receive rules: good stop bit delivers the byte, bad stop bit only flags.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      m_data  = b;
      m_avail = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_data = 8'h00; m_avail = 1'b0; m_err = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] b);
    tx_data = b;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    m_avail = 1'b0;
    m_err   = 1'b0;
  endtask

  // Serial frame on the RX pin. A bad stop bit is held low only past its
  // middle so the line is idle again before any false start is confirmed.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = fr[i];
      if (i == 9 && !stop) begin
        repeat (BIT_CLKS / 2 + 10) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (BIT_CLKS / 2 - 10) @(negedge clk);
      end else begin
        repeat (BIT_CLKS) @(negedge clk);
      end
    end
    rxd_drv = 1'b1;
  endtask

  // Start right after tx_write: check fall latency, then each bit at mid-bit.
  task automatic sample_tx_frame(input logic [7:0] b);
    logic [9:0] fr;
    int n;
    fr = {1'b1, b, 1'b0};
    n = 0;
    while (uart_txd !== 1'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_range("tx_fall_latency", n, 0, 1);
    repeat (BIT_CLKS / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx_bit%0d_of_%02h", k, b), {31'h0, uart_txd}, {31'h0, fr[k]});
      if (k < 9) repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic measure_busy();
    int n;
    n = 0;
    check("tx_busy_rise", {31'h0, tx_busy}, 32'h1);
    while (tx_busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_range("tx_busy_len", n, FRAME - DIV, FRAME + DIV);
  endtask

  task automatic wait_busy_low();
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_range("tx_busy_fall_wait", n, 0, 1999);
  endtask

  task automatic wait_rx_byte();
    int n;
    logic [7:0] e;
    n = 0;
    while (rx_avail !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    check("rx_avail_seen", {31'h0, rx_avail}, 32'h1);
    check("rx_byte", {24'h0, rx_data}, {24'h0, e});
    check("rx_no_error", {31'h0, rx_error}, 32'h0);
    m_data = e;
    do_ack();
  endtask

  // Hold ack over the expected completion window, release once the new byte lands.
  task automatic ack_window(input logic [7:0] b);
    int n;
    repeat (9 * BIT_CLKS) @(negedge clk);
    rx_ack = 1'b1;
    n = 0;
    while (rx_data !== b && n < 120) begin
      @(negedge clk);
      n++;
    end
    rx_ack = 1'b0;
    check_range("collision_window", n, 0, 119);
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    logic [7:0] b;
    logic       s;
    m_data = 8'h00; m_avail = 1'b0; m_err = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("reset_txd", {31'h0, uart_txd}, 32'h1);
    check("reset_busy", {31'h0, tx_busy}, 32'h0);
    check("reset_fsms_idle", {28'h0, dbg_state}, 32'h0);
    check_model("reset");

    // Loopback 0x55 then 0xA5
    loop_en = 1'b1;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA5);
    tx_write(8'h55);
    wait_rx_byte();
    wait_busy_low();
    tx_write(8'hA5);
    check("tx_wr_first_idle_cycle", {31'h0, tx_busy}, 32'h1);
    sample_tx_frame(8'hA5);
    wait_rx_byte();
    wait_busy_low();

    // TX waveform 0x3C plus busy length
    exp_q.push_back(8'h3C);
    tx_write(8'h3C);
    fork
      sample_tx_frame(8'h3C);
      measure_busy();
    join
    wait_rx_byte();

    // Random loopback bytes
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      tx_write(b);
      fork
        sample_tx_frame(b);
        measure_busy();
      join
      wait_rx_byte();
    end

    // Framing error: 0x81 with a low stop bit
    loop_en = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h81, 1'b0);
    model_frame(8'h81, 1'b0);
    check_model("frame_err");
    do_ack();
    check_model("frame_err_ack");

    // Random RX frames with occasional bad stop bits and random acks
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      send_frame(b, s);
      model_frame(b, s);
      check_model($sformatf("rand_rx%0d", i));
      if ($urandom_range(0, 1) == 1) do_ack();
    end
    do_ack();
    check_model("rand_rx_cleared");

    // Glitch: 20-clock low pulse must be rejected
    rxd_drv = 1'b0;
    repeat (20) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (FRAME) @(negedge clk);
    check_model("glitch");

    // Write while busy is ignored
    loop_en = 1'b1;
    exp_q.push_back(8'h12);
    tx_write(8'h12);
    fork
      sample_tx_frame(8'h12);
      begin
        repeat (200) @(negedge clk);
        tx_write(8'hFF);
      end
    join
    wait_rx_byte();
    wait_busy_low();
    repeat (FRAME + 100) @(negedge clk);
    check("busy_write_no_second_frame", {31'h0, rx_avail}, 32'h0);
    check("busy_write_line_idle", {31'h0, uart_txd}, 32'h1);

    // Overrun (back-to-back, no ack) and ack/completion collision
    loop_en = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    model_frame(8'h22, 1'b1);
    check_model("overrun");
    fork
      send_frame(8'h33, 1'b1);
      ack_window(8'h33);
    join
    m_err = 1'b0;
    model_frame(8'h33, 1'b1);
    check_model("collision");
    do_ack();

    // Reset during TX data bit 4
    tx_write(8'h5A);
    repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    check("pre_reset_busy", {31'h0, tx_busy}, 32'h1);
    reset_n = 1'b0;
    @(negedge clk);
    check("midframe_reset_txd", {31'h0, uart_txd}, 32'h1);
    check("midframe_reset_busy", {31'h0, tx_busy}, 32'h0);
    reset_n = 1'b1;
    m_data = 8'h00; m_avail = 1'b0; m_err = 1'b0;
    check_model("midframe_reset");
    @(negedge clk);
    loop_en = 1'b1;
    exp_q.push_back(8'h96);
    tx_write(8'h96);
    fork
      sample_tx_frame(8'h96);
      measure_busy();
    join
    wait_rx_byte();
    check("scoreboard_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global bound so a stuck DUT cannot hang the run.
  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

endmodule
